mmu_tlb: RTL and testbench
==========================

# mmu_tlb

Fully associative, software-managed TLB. Answers the translation requests the fixed-map MMU flags as mapped (kuseg/kseg2/kseg3). The MMU front end forwards a mapped virtual address, and this block returns the physical address, cacheability and exception flags one cycle later. CP0 writes entries through a TLBWI/TLBWR/TLBP command port.

## Interface
Parameters:
- TLB_ENTRIES, 16: entry count; power of two, 4..32.
- ASID_W, 8: ASID width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  translation request.
- req_ready  out  1  request accepted when valid & ready.
- req_vaddr  in  32  virtual address.
- req_store  in  1  request is a store (dirty check).
- req_asid  in  ASID_W  current ASID.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_paddr  out  32  physical address.
- rsp_uncached  out  1  page cache attribute C == 3'd2.
- rsp_miss  out  1  no matching entry.
- rsp_invalid  out  1  matched, but the selected V bit is 0.
- rsp_modified  out  1  store to a matched, valid page whose D bit is 0.
- tlb_op  in  2  0 none, 1 TLBWI, 2 TLBWR, 3 TLBP; single-cycle strobe.
- tlb_index  in  $clog2(TLB_ENTRIES)  index for TLBWI and for the read port.
- entryhi_i  in  32  fields: VPN2 [31:13], ASID [ASID_W-1:0].
- entrylo0_i, entrylo1_i  in  32 each  fields: PFN [25:6], C [5:3], D [2], V [1], G [0].
- rd_entryhi, rd_entrylo0, rd_entrylo1  out  32 each  combinational read of entry[tlb_index] (TLBR).
- probe_done  out  1  TLBP result pulse.
- probe_hit  out  1  TLBP found a match.
- probe_index  out  $clog2(TLB_ENTRIES)  index of the matching entry.
- random_o  out  $clog2(TLB_ENTRIES)  current Random value.

## Operation
- Entry contents: VPN2, ASID, G, and two page halves {PFN, C, D, V}.
  - G is stored as lo0.G & lo1.G.
  - Page size is fixed at 4 KB; there is no PageMask.
- Match rule: VPN2 == vaddr[31:13] && (G || ASID == req_asid). On multiple hits, the lowest index wins.
- Half select: vaddr[12] picks lo1 when 1, lo0 when 0.
- Physical address: rsp_paddr = {PFN, vaddr[11:0]}.
- Flag priority: miss > invalid > modified.
  - On a miss, rsp_paddr = 0 and rsp_uncached = 0.
- TLBWI: writes entry[tlb_index].
- TLBWR: writes entry[random_o].
- TLBP: compares entryhi_i (VPN2 and ASID) against all entries using the match rule.
- Random counter:
  - Decrements by 1 every cycle.
  - Wraps from 0 to TLB_ENTRIES-1.
  - Does not stall on TLBWR.
- Reset values:
  - Every entry is cleared (V=0, G=0, VPN2=0).
  - random_o = TLB_ENTRIES-1.
  - All rsp_* and probe_* outputs are 0.
- Reset asserted mid-operation: a pending response is dropped, and no rsp_valid pulse appears after reset releases.

## Timing
- req_ready = (tlb_op == 0). Any CP0 command blocks acceptance in that cycle.
- Lookup latency:
  - A request accepted in cycle N gets a registered response in cycle N+1, with rsp_valid high for exactly one cycle.
  - Throughput is one request per cycle.
- A request accepted in cycle N sees every entry write committed at the end of cycle N-1 or earlier.
- TLB writes commit at the clock edge. A read-port access in the next cycle returns the new value.
- TLBP:
  - probe_done pulses in cycle N+1.
  - probe_hit and probe_index hold their values until the next TLBP or reset.
- A TLBWR in cycle N uses the random_o value visible during cycle N.

## Configuration
- MMU_TLB_PROBE_EN defined: TLBP logic is present as described above.
- MMU_TLB_PROBE_EN undefined:
  - tlb_op == 3 is a no-op; it still deasserts req_ready for that cycle.
  - probe_done, probe_hit and probe_index are tied to 0.

## Structure
- Package mmu_tlb_pkg holds:
  - the entry struct and lo-half struct;
  - the tlb_op encodings;
  - the uncached C constant (3'd2);
  - the field bit positions.
- Sub-module mmu_tlb_match: a single-entry comparator (VPN2/ASID/G match). It is instantiated TLB_ENTRIES times and shared by lookup and probe through an input mux.

## Test plan
- After reset, request vaddr 0x0040_1000 -> next cycle: rsp_valid=1, rsp_miss=1, rsp_paddr=0; random_o==15 during the first cycle after reset.
- TLBWI index 3 (VPN2=0x00200, ASID 5, lo0 PFN=0x01234, V=1, D=1, C=3), then request vaddr 0x0040_0ABC with asid 5 -> rsp_paddr=0x0123_4ABC, rsp_uncached=0, no flags. The same request with asid 6 -> rsp_miss=1.
- Same entry with lo1 V=1, D=0, C=2: store to vaddr 0x0040_1010 -> rsp_modified=1 and rsp_uncached=1. A load to the same address -> no flags.
- Entries 2 and 7 both matching with G=1 -> the response uses entry 2's PFN.
- TLBP with matching entryhi -> probe_done pulses one cycle later with probe_hit=1, probe_index=3. With a non-matching entryhi -> probe_hit=0. With the macro undefined -> probe_done stays 0.
- req_valid held high while tlb_op=2 -> req_ready=0 that cycle; the request is accepted the next cycle and sees the entry just written at the captured random_o.

Source files
------------

// File: rtl/mmu_tlb_pkg.sv
// mmu_tlb_pkg: shared entry types, CP0 field positions and command encodings for the TLB.
package mmu_tlb_pkg;

  localparam int VPN2_MSB   = 31;
  localparam int VPN2_LSB   = 13;
  localparam int HALF_BIT   = 12;
  localparam int OFFS_MSB   = 11;
  localparam int PFN_MSB    = 25;
  localparam int PFN_LSB    = 6;
  localparam int C_MSB      = 5;
  localparam int C_LSB      = 3;
  localparam int D_BIT      = 2;
  localparam int V_BIT      = 1;
  localparam int G_BIT      = 0;

  localparam int VPN2_W     = VPN2_MSB - VPN2_LSB + 1;
  localparam int PFN_W      = PFN_MSB - PFN_LSB + 1;
  // The ASID field of EntryHi lives below VPN2, so it can never exceed 13 bits.
  localparam int ASID_MAX_W = VPN2_LSB;

  typedef enum logic [1:0] {
    TLB_OP_NONE = 2'd0,
    TLB_OP_WI   = 2'd1,
    TLB_OP_WR   = 2'd2,
    TLB_OP_P    = 2'd3
  } tlb_op_e;

  localparam logic [2:0] C_UNCACHED = 3'd2;

  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
  } tlb_lo_t;

  typedef struct packed {
    logic [VPN2_W-1:0]     vpn2;
    logic [ASID_MAX_W-1:0] asid;
    logic                  g;
    tlb_lo_t               lo0;
    tlb_lo_t               lo1;
  } tlb_entry_t;

  function automatic logic [31:0] pack_lo(input tlb_lo_t lo, input logic g);
    logic [31:0] w;
    w                  = '0;
    w[PFN_MSB:PFN_LSB] = lo.pfn;
    w[C_MSB:C_LSB]     = lo.c;
    w[D_BIT]           = lo.d;
    w[V_BIT]           = lo.v;
    w[G_BIT]           = g;
    return w;
  endfunction

endpackage

// File: rtl/mmu_tlb_match.sv
// mmu_tlb_match: single-entry VPN2/ASID/G comparator, one instance per TLB entry.
module mmu_tlb_match
  import mmu_tlb_pkg::*;
#(
  parameter int ASID_W = 8
) (
  input  logic [VPN2_W-1:0] entry_vpn2_i,
  input  logic [ASID_W-1:0] entry_asid_i,
  input  logic              entry_g_i,
  input  logic [VPN2_W-1:0] cmp_vpn2_i,
  input  logic [ASID_W-1:0] cmp_asid_i,
  output logic              hit_o
);

  assign hit_o = (entry_vpn2_i == cmp_vpn2_i) &&
                 (entry_g_i || (entry_asid_i == cmp_asid_i));

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: fully associative software-managed TLB with a one-cycle registered lookup.
// Define MMU_TLB_PROBE_EN to build the TLBP probe logic; otherwise probe outputs are tied low.
module mmu_tlb
  import mmu_tlb_pkg::*;
#(
  parameter  int TLB_ENTRIES = 16,
  parameter  int ASID_W      = 8,
  localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vaddr,
  input  logic              req_store,
  input  logic [ASID_W-1:0] req_asid,
  output logic              rsp_valid,
  output logic [31:0]       rsp_paddr,
  output logic              rsp_uncached,
  output logic              rsp_miss,
  output logic              rsp_invalid,
  output logic              rsp_modified,
  input  logic [1:0]        tlb_op,
  input  logic [IDX_W-1:0]  tlb_index,
  input  logic [31:0]       entryhi_i,
  input  logic [31:0]       entrylo0_i,
  input  logic [31:0]       entrylo1_i,
  output logic [31:0]       rd_entryhi,
  output logic [31:0]       rd_entrylo0,
  output logic [31:0]       rd_entrylo1,
  output logic              probe_done,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index,
  output logic [IDX_W-1:0]  random_o
);

  tlb_entry_t             entries_q [TLB_ENTRIES];
  tlb_entry_t             wr_entry;
  tlb_entry_t             hit_entry;
  tlb_entry_t             rd_entry;
  tlb_lo_t                lo_sel;

  logic [IDX_W-1:0]       random_q, random_d;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_idx;
  logic                   req_fire;

  logic [VPN2_W-1:0]      cmp_vpn2;
  logic [ASID_W-1:0]      cmp_asid;
  logic [TLB_ENTRIES-1:0] hit_vec;
  logic                   hit_any;
  logic [IDX_W-1:0]       hit_idx;

  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_paddr_q, rsp_paddr_d;
  logic                   rsp_uncached_q, rsp_uncached_d;
  logic                   rsp_miss_q, rsp_miss_d;
  logic                   rsp_invalid_q, rsp_invalid_d;
  logic                   rsp_modified_q, rsp_modified_d;

  logic                   unused_bits;

  assign req_ready = (tlb_op == TLB_OP_NONE);
  assign req_fire  = req_valid && req_ready;

  // Random down-counter; free-running, including across TLBWR.
  assign random_d = (random_q == '0) ? IDX_W'(TLB_ENTRIES - 1) : random_q - 1'b1;
  assign random_o = random_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      random_q <= IDX_W'(TLB_ENTRIES - 1);
    end else begin
      random_q <= random_d;
    end
  end

  // Entry write path.
  assign wr_en  = (tlb_op == TLB_OP_WI) || (tlb_op == TLB_OP_WR);
  assign wr_idx = (tlb_op == TLB_OP_WR) ? random_q : tlb_index;

  always_comb begin
    wr_entry          = '0;
    wr_entry.vpn2     = entryhi_i[VPN2_MSB:VPN2_LSB];
    wr_entry.asid     = ASID_MAX_W'(entryhi_i[ASID_W-1:0]);
    wr_entry.g        = entrylo0_i[G_BIT] & entrylo1_i[G_BIT];
    wr_entry.lo0.pfn  = entrylo0_i[PFN_MSB:PFN_LSB];
    wr_entry.lo0.c    = entrylo0_i[C_MSB:C_LSB];
    wr_entry.lo0.d    = entrylo0_i[D_BIT];
    wr_entry.lo0.v    = entrylo0_i[V_BIT];
    wr_entry.lo1.pfn  = entrylo1_i[PFN_MSB:PFN_LSB];
    wr_entry.lo1.c    = entrylo1_i[C_MSB:C_LSB];
    wr_entry.lo1.d    = entrylo1_i[D_BIT];
    wr_entry.lo1.v    = entrylo1_i[V_BIT];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (wr_en) begin
      entries_q[wr_idx] <= wr_entry;
    end
  end

  assign unused_bits = ^{entryhi_i[VPN2_LSB-1:ASID_W],
                         entrylo0_i[31:PFN_MSB+1], entrylo1_i[31:PFN_MSB+1]};

  // Comparators are shared: a probe cycle never accepts a request, so the key can be muxed.
`ifdef MMU_TLB_PROBE_EN
  assign cmp_vpn2 = (tlb_op == TLB_OP_P) ? entryhi_i[VPN2_MSB:VPN2_LSB] : req_vaddr[VPN2_MSB:VPN2_LSB];
  assign cmp_asid = (tlb_op == TLB_OP_P) ? entryhi_i[ASID_W-1:0]        : req_asid;
`else
  assign cmp_vpn2 = req_vaddr[VPN2_MSB:VPN2_LSB];
  assign cmp_asid = req_asid;
`endif

  for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_match
    mmu_tlb_match #(
      .ASID_W (ASID_W)
    ) u_match (
      .entry_vpn2_i (entries_q[i].vpn2),
      .entry_asid_i (entries_q[i].asid[ASID_W-1:0]),
      .entry_g_i    (entries_q[i].g),
      .cmp_vpn2_i   (cmp_vpn2),
      .cmp_asid_i   (cmp_asid),
      .hit_o        (hit_vec[i])
    );
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_entry = entries_q[hit_idx];

  always_comb begin
    lo_sel         = req_vaddr[HALF_BIT] ? hit_entry.lo1 : hit_entry.lo0;
    rsp_valid_d    = req_fire;
    rsp_paddr_d    = '0;
    rsp_uncached_d = 1'b0;
    rsp_miss_d     = 1'b0;
    rsp_invalid_d  = 1'b0;
    rsp_modified_d = 1'b0;
    if (req_fire) begin
      if (!hit_any) begin
        rsp_miss_d = 1'b1;
      end else begin
        rsp_paddr_d    = {lo_sel.pfn, req_vaddr[OFFS_MSB:0]};
        rsp_uncached_d = (lo_sel.c == C_UNCACHED);
        rsp_invalid_d  = !lo_sel.v;
        rsp_modified_d = lo_sel.v && req_store && !lo_sel.d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_paddr_q    <= '0;
      rsp_uncached_q <= 1'b0;
      rsp_miss_q     <= 1'b0;
      rsp_invalid_q  <= 1'b0;
      rsp_modified_q <= 1'b0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_paddr_q    <= rsp_paddr_d;
      rsp_uncached_q <= rsp_uncached_d;
      rsp_miss_q     <= rsp_miss_d;
      rsp_invalid_q  <= rsp_invalid_d;
      rsp_modified_q <= rsp_modified_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_paddr    = rsp_paddr_q;
  assign rsp_uncached = rsp_uncached_q;
  assign rsp_miss     = rsp_miss_q;
  assign rsp_invalid  = rsp_invalid_q;
  assign rsp_modified = rsp_modified_q;

  // TLBR read port.
  assign rd_entry    = entries_q[tlb_index];
  assign rd_entryhi  = {rd_entry.vpn2, rd_entry.asid};
  assign rd_entrylo0 = pack_lo(rd_entry.lo0, rd_entry.g);
  assign rd_entrylo1 = pack_lo(rd_entry.lo1, rd_entry.g);

`ifdef MMU_TLB_PROBE_EN
  logic             probe_done_q, probe_done_d;
  logic             probe_hit_q, probe_hit_d;
  logic [IDX_W-1:0] probe_index_q, probe_index_d;

  always_comb begin
    probe_done_d  = (tlb_op == TLB_OP_P);
    probe_hit_d   = probe_hit_q;
    probe_index_d = probe_index_q;
    if (tlb_op == TLB_OP_P) begin
      probe_hit_d   = hit_any;
      probe_index_d = hit_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      probe_done_q  <= 1'b0;
      probe_hit_q   <= 1'b0;
      probe_index_q <= '0;
    end else begin
      probe_done_q  <= probe_done_d;
      probe_hit_q   <= probe_hit_d;
      probe_index_q <= probe_index_d;
    end
  end

  assign probe_done  = probe_done_q;
  assign probe_hit   = probe_hit_q;
  assign probe_index = probe_index_q;
`else
  assign probe_done  = 1'b0;
  assign probe_hit   = 1'b0;
  assign probe_index = '0;
`endif

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: scoreboard bench for mmu_tlb; directed plan cases followed by random traffic.
module tb_mmu_tlb;

  localparam int N = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic [7:0]  req_asid;
  logic        rsp_valid;
  logic [31:0] rsp_paddr;
  logic        rsp_uncached, rsp_miss, rsp_invalid, rsp_modified;
  logic [1:0]  tlb_op;
  logic [3:0]  tlb_index;
  logic [31:0] entryhi_i, entrylo0_i, entrylo1_i;
  logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1;
  logic        probe_done, probe_hit;
  logic [3:0]  probe_index;
  logic [3:0]  random_o;

  mmu_tlb #(.TLB_ENTRIES(N), .ASID_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_vaddr    (req_vaddr),
    .req_store    (req_store),
    .req_asid     (req_asid),
    .rsp_valid    (rsp_valid),
    .rsp_paddr    (rsp_paddr),
    .rsp_uncached (rsp_uncached),
    .rsp_miss     (rsp_miss),
    .rsp_invalid  (rsp_invalid),
    .rsp_modified (rsp_modified),
    .tlb_op       (tlb_op),
    .tlb_index    (tlb_index),
    .entryhi_i    (entryhi_i),
    .entrylo0_i   (entrylo0_i),
    .entrylo1_i   (entrylo1_i),
    .rd_entryhi   (rd_entryhi),
    .rd_entrylo0  (rd_entrylo0),
    .rd_entrylo1  (rd_entrylo1),
    .probe_done   (probe_done),
    .probe_hit    (probe_hit),
    .probe_index  (probe_index),
    .random_o     (random_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rand_m  = N - 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference TLB contents
  logic [18:0] m_vpn2 [N];
  logic [7:0]  m_asid [N];
  logic        m_g    [N];
  logic [31:0] m_lo0  [N];
  logic [31:0] m_lo1  [N];

  // flags = {uncached, miss, invalid, modified}
  typedef struct {
    logic [31:0] paddr;
    logic [3:0]  flags;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_lo0[i] = '0; m_lo1[i] = '0;
    end
  endfunction

  function automatic exp_t model_lookup(input logic [31:0] va, input logic st, input logic [7:0] asid);
    exp_t        e;
    logic [31:0] lo;
    e.paddr = '0;
    e.flags = 4'b0100;
    e.cyc   = 0;
    for (int i = 0; i < N; i++) begin
      if (m_vpn2[i] == va[31:13] && (m_g[i] || m_asid[i] == asid)) begin
        lo      = va[12] ? m_lo1[i] : m_lo0[i];
        e.paddr = {lo[25:6], va[11:0]};
        e.flags = {lo[5:3] == 3'd2, 1'b0, !lo[1], lo[1] && st && !lo[2]};
        return e;
      end
    end
    return e;
  endfunction

  function automatic int model_probe(input logic [31:0] hi);
    for (int i = 0; i < N; i++) begin
      if (m_vpn2[i] == hi[31:13] && (m_g[i] || m_asid[i] == hi[7:0])) return i;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rand_m = (rand_m == 0) ? N - 1 : rand_m - 1;
    chk("random_o", 32'(random_o), 32'(rand_m));
  endtask

  task automatic issue_req(input logic [31:0] va, input logic st, input logic [7:0] asid,
                           input bit use_const, input logic [31:0] c_paddr, input logic [3:0] c_flags);
    exp_t e;
    req_valid = 1'b1; req_vaddr = va; req_store = st; req_asid = asid;
    #1;
    chk("req_ready", 32'(req_ready), 32'd1);
    e = model_lookup(va, st, asid);
    if (use_const) begin
      e.paddr = c_paddr;
      e.flags = c_flags;
    end
    e.cyc = cyc;
    exp_q.push_back(e);
    step();
    req_valid = 1'b0;
  endtask

  task automatic write_entry(input logic [1:0] op, input int idx,
                             input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    int widx;
    widx = (op == 2'd2) ? rand_m : idx;
    tlb_op = op; tlb_index = 4'(idx); entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1;
    #1;
    chk("req_ready_wr", 32'(req_ready), 32'd0);
    m_vpn2[widx] = hi[31:13]; m_asid[widx] = hi[7:0]; m_g[widx] = lo0[0] & lo1[0];
    m_lo0[widx] = lo0; m_lo1[widx] = lo1;
    step();
    tlb_op = 2'd0;
    tlb_index = 4'(widx);
    #1;
    chk("rd_entryhi", rd_entryhi, {m_vpn2[widx], 5'd0, m_asid[widx]});
    chk("rd_entrylo0", rd_entrylo0, (m_lo0[widx] & 32'h03FF_FFFE) | 32'(m_g[widx]));
    chk("rd_entrylo1", rd_entrylo1, (m_lo1[widx] & 32'h03FF_FFFE) | 32'(m_g[widx]));
  endtask

  task automatic do_probe(input logic [31:0] hi);
    int pidx;
    pidx = model_probe(hi);
    tlb_op = 2'd3; entryhi_i = hi;
    #1;
    chk("req_ready_probe", 32'(req_ready), 32'd0);
    step();
    tlb_op = 2'd0;
`ifdef MMU_TLB_PROBE_EN
    chk("probe_done", 32'(probe_done), 32'd1);
    chk("probe_hit", 32'(probe_hit), 32'(pidx >= 0));
    if (pidx >= 0) chk("probe_index", 32'(probe_index), 32'(pidx));
`else
    chk("probe_done_off", 32'(probe_done), 32'd0);
    chk("probe_hit_off", 32'(probe_hit), 32'd0);
`endif
    step();
    chk("probe_done_pulse", 32'(probe_done), 32'd0);
  endtask

  // Monitor: pops one expectation per response and checks its timing and contents.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.cyc + 1));
          chk("rsp_paddr", rsp_paddr, e.paddr);
          chk("rsp_flags", 32'({rsp_uncached, rsp_miss, rsp_invalid, rsp_modified}), 32'(e.flags));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc + 1 <= cyc) begin
        e = exp_q.pop_front();
        chk("rsp_missing", 32'(rsp_valid), 32'd1);
      end
    end
  end

  logic [18:0] pool [4];

  initial begin
    pool[0] = 19'h00200; pool[1] = 19'h00201; pool[2] = 19'h7FFFF; pool[3] = 19'h00000;
    rst = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0; req_asid = '0;
    tlb_op = 2'd0; tlb_index = '0; entryhi_i = '0; entrylo0_i = '0; entrylo1_i = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rand_m = N - 1;
    chk("reset_random", 32'(random_o), 32'd15);
    chk("reset_rsp", 32'({rsp_valid, rsp_uncached, rsp_miss, rsp_invalid, rsp_modified}), 32'd0);
    chk("reset_rsp_paddr", rsp_paddr, 32'd0);
    chk("reset_probe", 32'({probe_done, probe_hit, probe_index}), 32'd0);

    issue_req(32'h0040_1000, 1'b0, 8'd0, 1'b1, 32'h0, 4'b0100);

    write_entry(2'd1, 3, 32'h0040_0005, 32'h0004_8D1E, 32'h0);
    issue_req(32'h0040_0ABC, 1'b0, 8'd5, 1'b1, 32'h0123_4ABC, 4'b0000);
    issue_req(32'h0040_0ABC, 1'b0, 8'd6, 1'b1, 32'h0, 4'b0100);

    write_entry(2'd1, 3, 32'h0040_0005, 32'h0004_8D1E, 32'h0000_1552);
    issue_req(32'h0040_1010, 1'b1, 8'd5, 1'b1, 32'h0005_5010, 4'b1001);
    issue_req(32'h0040_1010, 1'b0, 8'd5, 1'b1, 32'h0005_5010, 4'b1000);

    write_entry(2'd1, 7, 32'h0060_0001, 32'h02AA_AA9F, 32'h0000_0001);
    write_entry(2'd1, 2, 32'h0060_0001, 32'h0002_EEDF, 32'h0000_0001);
    issue_req(32'h0060_0123, 1'b0, 8'd9, 1'b1, 32'h00BB_B123, 4'b0000);

    write_entry(2'd1, 5, 32'h0080_0002, 32'h0001_DDD8, 32'h0);
    issue_req(32'h0080_0044, 1'b1, 8'd2, 1'b1, 32'h0077_7044, 4'b0010);

    do_probe(32'h0040_0005);
    do_probe(32'h00A0_0005);

    // TLBWR while a request waits; the request goes through the cycle after.
    begin
      exp_t e;
      int   widx;
      req_valid = 1'b1; req_vaddr = 32'h00C0_0555; req_store = 1'b0; req_asid = 8'd3;
      tlb_op = 2'd2; entryhi_i = 32'h00C0_0003; entrylo0_i = 32'h0000_C85E; entrylo1_i = 32'h0;
      widx = rand_m;
      #1;
      chk("req_ready_wr_held", 32'(req_ready), 32'd0);
      m_vpn2[widx] = 19'h00600; m_asid[widx] = 8'd3; m_g[widx] = 1'b0;
      m_lo0[widx] = 32'h0000_C85E; m_lo1[widx] = 32'h0;
      step();
      tlb_op = 2'd0;
      #1;
      chk("req_ready_after_wr", 32'(req_ready), 32'd1);
      e.paddr = 32'h0032_1555; e.flags = 4'b0000; e.cyc = cyc;
      exp_q.push_back(e);
      step();
      req_valid = 1'b0;
      tlb_index = 4'(widx);
      #1;
      chk("rd_entryhi_wr", rd_entryhi, 32'h00C0_0003);
    end

    for (int k = 0; k < 400; k++) begin
      int          r;
      logic [31:0] hi;
      r  = $urandom_range(0, 99);
      hi = {pool[$urandom_range(0, 3)], 13'($urandom())};
      hi[7:0] = 8'($urandom_range(0, 3));
      if (r < 55) begin
        issue_req({pool[$urandom_range(0, 3)], 13'($urandom())}, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 3)), 1'b0, 32'h0, 4'h0);
      end else if (r < 70) begin
        write_entry(2'd1, $urandom_range(0, N - 1), hi, $urandom(), $urandom());
      end else if (r < 80) begin
        write_entry(2'd2, 0, hi, $urandom(), $urandom());
      end else if (r < 88) begin
        do_probe(hi);
      end else begin
        step();
      end
    end

    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a response is on the outputs: it must vanish and not reappear.
    req_valid = 1'b1; req_vaddr = 32'h0040_0ABC; req_store = 1'b0; req_asid = 8'd5;
    step();
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("reset_drop_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rand_m = N - 1;
    model_clear();
    chk("reset2_random", 32'(random_o), 32'd15);
    tlb_index = 4'd3;
    #1;
    chk("reset2_rd_entrylo0", rd_entrylo0, 32'h0);
    step();
    step();
    chk("reset2_no_rsp", 32'(rsp_valid), 32'd0);
    issue_req(32'h0040_0ABC, 1'b0, 8'd5, 1'b1, 32'h0, 4'b0100);
    step();
    step();
    chk("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
